// File: rtl/vga_sprite_addr_gen.sv
// vga_sprite_addr_gen: per-pixel background/sprite address generator for a 640x480 scan
// Ports:
//   clock, reset               clock, asynchronous active-high reset
//   frame_start                one-cycle pulse: rewind to (0,0), latch scene inputs
//   pixel_valid                advance-one-pixel strobe
//   game_state                 0 title, 1 playing, 2 game over, 3 as title
//   bird_x/y, pipeN_x/gap      scene positions (latched at frame_start)
//   score_bcd                  two BCD score digits (latched at frame_start)
//   oaddress                   background address y*640+x
//   address, mask              sprite address and sprite select
//   out_valid                  one-cycle strobe, one cycle after each accepted pixel
module vga_sprite_addr_gen #(
   parameter int BIRD_W  = 64,
   parameter int BIRD_H  = 32,
   parameter int PIPE_W  = 80,
   parameter int GAP     = 120,
   parameter int DIGIT_W = 24,
   parameter int DIGIT_H = 32,
   parameter int SCORE_X = 296,
   parameter int SCORE_Y = 40,
   parameter int GG_X    = 220,
   parameter int GG_Y    = 180,
   parameter int GG_W    = 200,
   parameter int GG_H    = 60,
   parameter int TI_X    = 200,
   parameter int TI_Y    = 100,
   parameter int TI_W    = 240,
   parameter int TI_H    = 80
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        pixel_valid,
   input  logic [1:0]  game_state,
   input  logic [9:0]  bird_x,
   input  logic [8:0]  bird_y,
   input  logic [9:0]  pipe0_x,
   input  logic [9:0]  pipe1_x,
   input  logic [8:0]  pipe0_gap,
   input  logic [8:0]  pipe1_gap,
   input  logic [7:0]  score_bcd,
   output logic [18:0] oaddress,
   output logic [18:0] address,
   output logic [2:0]  mask,
   output logic        out_valid
);
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
   state_t state_q, state_d;
   logic [9:0]  x, bx, p0x, p1x;
   logic [8:0]  y, by, p0g, p1g;
   logic [7:0]  sc;
   logic [1:0]  st;
   logic [10:0] xe, ye, sx, col;
   logic [3:0]  digit;
   logic        accept, last, bird_hit, p0_hit, p1_hit, pipe_hit, num_hit, gg_hit, ti_hit;
   logic [18:0] oa, bird_a, p0_a, p1_a, pipe_a, num_a, gg_a, ti_a, a_d;
   logic [2:0]  m_d;
   // frame_start wins over a coincident pixel_valid, which is dropped
   assign accept = state_q == ACTIVE && pixel_valid && !frame_start;
   assign last   = x == 10'd639 && y == 9'd479;
   assign xe = {1'b0, x};
   assign ye = {2'b0, y};
   // all range checks at 11 bits so sprites near the right/bottom edge clip instead of wrapping
   assign bird_hit = xe >= {1'b0, bx} && xe < {1'b0, bx} + 11'(BIRD_W) &&
                     ye >= {2'b0, by} && ye < {2'b0, by} + 11'(BIRD_H);
   assign p0_hit = xe >= {1'b0, p0x} && xe < {1'b0, p0x} + 11'(PIPE_W) &&
                   !(ye >= {2'b0, p0g} && ye < {2'b0, p0g} + 11'(GAP));
   assign p1_hit = xe >= {1'b0, p1x} && xe < {1'b0, p1x} + 11'(PIPE_W) &&
                   !(ye >= {2'b0, p1g} && ye < {2'b0, p1g} + 11'(GAP));
   assign pipe_hit = p0_hit || p1_hit;
   assign sx    = xe - 11'(SCORE_X);
   assign digit = sx >= 11'(DIGIT_W) ? sc[3:0] : sc[7:4];
   assign col   = sx >= 11'(DIGIT_W) ? sx - 11'(DIGIT_W) : sx;
   assign num_hit = ye >= 11'(SCORE_Y) && ye < 11'(SCORE_Y + DIGIT_H) &&
                    xe >= 11'(SCORE_X) && xe < 11'(SCORE_X + 2 * DIGIT_W) && digit <= 4'd9;
   assign gg_hit = xe >= 11'(GG_X) && xe < 11'(GG_X + GG_W) && ye >= 11'(GG_Y) && ye < 11'(GG_Y + GG_H);
   assign ti_hit = xe >= 11'(TI_X) && xe < 11'(TI_X + TI_W) && ye >= 11'(TI_Y) && ye < 11'(TI_Y + TI_H);
   assign oa     = 19'(y) * 19'd640 + 19'(x);
   assign bird_a = 19'(y - by) * 19'(BIRD_W) + 19'(x - bx);
   assign p0_a   = 19'(y) * 19'(PIPE_W) + 19'(x - p0x);
   assign p1_a   = 19'(y) * 19'(PIPE_W) + 19'(x - p1x);
   assign pipe_a = p0_hit ? p0_a : p1_a;
   // digit sheet holds all ten glyphs side by side, one row of 10*DIGIT_W pixels per line
   assign num_a  = 19'(ye - 11'(SCORE_Y)) * 19'(10 * DIGIT_W) + 19'(digit) * 19'(DIGIT_W) + 19'(col);
   assign gg_a   = 19'(ye - 11'(GG_Y)) * 19'(GG_W) + 19'(xe - 11'(GG_X));
   assign ti_a   = 19'(ye - 11'(TI_Y)) * 19'(TI_W) + 19'(xe - 11'(TI_X));
   always_comb begin
      state_d = state_q;
      if (frame_start)
         state_d = ACTIVE;
      else if (accept && last)
         state_d = DONE;
   end
   always_comb begin
      m_d = 3'd0;
      a_d = oa;
      if (st == 2'd1) begin
         if (bird_hit) begin m_d = 3'd1; a_d = bird_a; end
         else if (num_hit) begin m_d = 3'd3; a_d = num_a; end
         else if (pipe_hit) begin m_d = 3'd2; a_d = pipe_a; end
      end else if (st == 2'd2) begin
         if (gg_hit) begin m_d = 3'd4; a_d = gg_a; end
         else if (num_hit) begin m_d = 3'd3; a_d = num_a; end
         else if (bird_hit) begin m_d = 3'd1; a_d = bird_a; end
         else if (pipe_hit) begin m_d = 3'd2; a_d = pipe_a; end
      end else begin
         if (ti_hit) begin m_d = 3'd5; a_d = ti_a; end
         else if (bird_hit) begin m_d = 3'd1; a_d = bird_a; end
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         x         <= '0;
         y         <= '0;
         bx        <= '0;
         by        <= '0;
         p0x       <= '0;
         p1x       <= '0;
         p0g       <= '0;
         p1g       <= '0;
         sc        <= '0;
         st        <= '0;
         oaddress  <= '0;
         address   <= '0;
         mask      <= '0;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_valid <= accept;
         if (frame_start) begin
            x   <= '0;
            y   <= '0;
            bx  <= bird_x;
            by  <= bird_y;
            p0x <= pipe0_x;
            p1x <= pipe1_x;
            p0g <= pipe0_gap;
            p1g <= pipe1_gap;
            sc  <= score_bcd;
            st  <= game_state;
         end else if (accept) begin
            oaddress <= oa;
            address  <= a_d;
            mask     <= m_d;
            x        <= x == 10'd639 ? 10'd0 : x + 10'd1;
            y        <= x != 10'd639 ? y : (y == 9'd479 ? 9'd0 : y + 9'd1);
         end
      end
   end
endmodule

// File: tb/tb_vga_sprite_addr_gen.sv
// tb_vga_sprite_addr_gen: directed checks of scan order, sprite hits, priorities and reset
module tb_vga_sprite_addr_gen;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic        pixel_valid = 1'b0;
   logic [1:0]  game_state = '0;
   logic [9:0]  bird_x = '0, pipe0_x = '0, pipe1_x = '0;
   logic [8:0]  bird_y = '0, pipe0_gap = '0, pipe1_gap = '0;
   logic [7:0]  score_bcd = '0;
   logic [18:0] oaddress, address;
   logic [2:0]  mask;
   logic        out_valid;
   int checks = 0, failures = 0, idx = 0;
   // game-over and title boxes moved near the top so they are reachable in a short scan
   vga_sprite_addr_gen #(.GG_Y(4), .GG_H(30), .TI_Y(8)) dut (
      .clock(clock), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
      .game_state(game_state), .bird_x(bird_x), .bird_y(bird_y), .pipe0_x(pipe0_x),
      .pipe1_x(pipe1_x), .pipe0_gap(pipe0_gap), .pipe1_gap(pipe1_gap), .score_bcd(score_bcd),
      .oaddress(oaddress), .address(address), .mask(mask), .out_valid(out_valid)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask
   task automatic fs();
      frame_start = 1'b1;
      @(posedge clock);
      #1 frame_start = 1'b0;
      idx = 0;
   endtask
   // stream pixels back to back up to (xx,yy); outputs then belong to that pixel
   task automatic goto(input int xx, input int yy);
      int t = yy * 640 + xx;
      pixel_valid = 1'b1;
      while (idx <= t) begin
         @(posedge clock);
         #1 idx++;
      end
      pixel_valid = 1'b0;
   endtask
   task automatic px(input string tag, input int xx, input int yy, input int m, input int a);
      goto(xx, yy);
      chk({tag, ".valid"}, 32'(out_valid), 1);
      chk({tag, ".oaddr"}, 32'(oaddress), 32'(yy * 640 + xx));
      chk({tag, ".mask"}, 32'(mask), 32'(m));
      chk({tag, ".addr"}, 32'(address), 32'(a));
   endtask
   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst.valid", 32'(out_valid), 0);
      chk("rst.mask", 32'(mask), 0);
      chk("rst.addr", 32'(address), 0);
      chk("rst.oaddr", 32'(oaddress), 0);
      reset = 1'b0;
      pixel_valid = 1'b1;
      repeat (2) @(posedge clock);
      #1 pixel_valid = 1'b0;
      chk("idle.ignore", 32'(out_valid), 0);
      // frame A: playing
      game_state = 2'd1; bird_x = 10'd100; bird_y = 9'd2;
      pipe0_x = 10'd300; pipe0_gap = 9'd20; pipe1_x = 10'd600; pipe1_gap = 9'd200;
      score_bcd = 8'h37;
      fs();
      bird_x = 10'd0; score_bcd = 8'h99;
      px("a.origin", 0, 0, 0, 0);
      px("a.row1", 0, 1, 0, 640);
      px("a.bird_tl", 100, 2, 1, 0);
      @(posedge clock);
      #1;
      chk("a.hold.valid", 32'(out_valid), 0);
      chk("a.hold.mask", 32'(mask), 1);
      chk("a.hold.oaddr", 32'(oaddress), 1380);
      px("a.bird_right", 164, 2, 0, 1444);
      px("a.pipe1_clip", 639, 5, 2, 439);
      px("a.pipe1_nowrap", 0, 6, 0, 3840);
      px("a.pipe0", 310, 10, 2, 810);
      px("a.pipe0_gap", 310, 25, 0, 16310);
      px("a.bird_br", 163, 33, 1, 2047);
      px("a.score", 320, 40, 3, 168);
      // frame B: game over
      game_state = 2'd2; bird_x = 10'd240; bird_y = 9'd0;
      pipe0_x = 10'd700; pipe1_x = 10'd700; score_bcd = 8'h3A;
      fs();
      px("b.bird", 250, 2, 1, 138);
      px("b.gg_over_bird", 250, 10, 4, 1230);
      px("b.gg", 250, 20, 4, 3230);
      px("b.score_left", 300, 40, 3, 76);
      px("b.score_bad", 320, 40, 0, 25920);
      // frame C: title, started with a coincident pixel_valid that must be dropped
      game_state = 2'd0; bird_x = 10'd100; bird_y = 9'd2;
      frame_start = 1'b1;
      pixel_valid = 1'b1;
      @(posedge clock);
      #1 frame_start = 1'b0;
      pixel_valid = 1'b0;
      idx = 0;
      chk("c.coincident", 32'(out_valid), 0);
      px("c.origin", 0, 0, 0, 0);
      px("c.bird", 100, 2, 1, 0);
      px("c.title", 210, 10, 5, 490);
      // frame D: asynchronous reset mid-frame
      game_state = 2'd1; pipe0_x = 10'd300; pipe0_gap = 9'd20;
      fs();
      px("d.pix1000", 360, 1, 2, 140);
      #2 reset = 1'b1;
      #1;
      chk("d.rst.valid", 32'(out_valid), 0);
      chk("d.rst.oaddr", 32'(oaddress), 0);
      chk("d.rst.addr", 32'(address), 0);
      chk("d.rst.mask", 32'(mask), 0);
      @(negedge clock);
      reset = 1'b0;
      pixel_valid = 1'b1;
      repeat (3) @(posedge clock);
      #1 pixel_valid = 1'b0;
      chk("d.after.valid", 32'(out_valid), 0);
      chk("d.after.oaddr", 32'(oaddress), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
